addsub_result_tx: RTL



---
 rtl/addsub_result_tx_pkg.sv | 16 +
 rtl/bcd_adj3.sv | 10 +
 rtl/addsub_result_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/addsub_result_tx_pkg.sv
// Shared types and character constants for the result-to-ASCII transmitter.
// Optional feature macro used by the top: ADDSUB_RESULT_TX_ERR_EN.
package addsub_result_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_BANG  = 8'h21;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/bcd_adj3.sv
// Single BCD nibble correction for shift-add-3 conversion: add 3 when nibble >= 5.
module bcd_adj3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib_c
);

    // Correct the nibble so the following left shift carries into the next decade.
    assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/addsub_result_tx.sv
// Streams one WIDTH-bit adder result as ASCII decimal followed by LF.
// Build option: define ADDSUB_RESULT_TX_ERR_EN to add the in_err port and emit
// '!' before LF when the captured overflow flag is set.
module addsub_result_tx
    import addsub_result_tx_pkg::*;
#(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned DIGITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_signed,
`ifdef ADDSUB_RESULT_TX_ERR_EN
    input  logic             in_err,
`endif
    output logic             char_valid,
    input  logic             char_ready,
    output logic [7:0]       char_data,
    output logic             busy
);

    localparam int unsigned BW        = 4 * DIGITS;
    localparam int unsigned CW        = $clog2(WIDTH + 1);
    localparam int unsigned PW        = $clog2(DIGITS + 3);
    // Emit slots: 0 = sign, 1..DIGITS = digits, then bang, then LF.
    localparam int unsigned SLOT_BANG = DIGITS + 1;
    localparam int unsigned SLOT_LF   = DIGITS + 2;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_char_valid;
    logic [7:0]       r_char_data;
    logic             r_neg;
    logic             r_err;
    logic [WIDTH-1:0] r_mag;
    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_ptr;

    logic             w_neg;
    logic             w_err_in;
    logic [BW-1:0]    w_adj;
    logic [PW-1:0]    w_first_ptr;
    logic [PW-1:0]    w_next_ptr;
    logic             w_unused_top;

`ifdef ADDSUB_RESULT_TX_ERR_EN
    assign w_err_in = in_err;
`else
    assign w_err_in = 1'b0;
`endif

    assign w_neg = in_signed & in_value[WIDTH-1];

    // Top bit of the corrected BCD is shifted out; it is always zero for legal sizes.
    assign w_unused_top = w_adj[BW-1];

    // One add-3 corrector per decimal digit.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_adj3 u_adj (
            .i_nib   (r_bcd[4*d +: 4]),
            .o_nib_c (w_adj[4*d +: 4])
        );
    end

    // Choose the first emitted slot and the slot following the current one.
    always_comb begin
        w_first_ptr = r_neg ? PW'(0) : PW'(1);
        w_next_ptr  = r_ptr + PW'(1);
        if ((w_next_ptr == PW'(SLOT_BANG)) && !r_err) begin
            w_next_ptr = PW'(SLOT_LF);
        end
    end

    // ASCII character for an emit slot.
    function automatic logic [7:0] slot_char(input logic [PW-1:0] ptr,
                                             input logic [BW-1:0] bcd);
        logic [7:0] ch;
        ch = ASCII_LF;
        if (ptr == PW'(0)) begin
            ch = ASCII_MINUS;
        end else if (ptr == PW'(SLOT_BANG)) begin
            ch = ASCII_BANG;
        end
        for (int d = 1; d <= int'(DIGITS); d++) begin
            if (ptr == PW'(d)) begin
                ch = ASCII_ZERO + {4'h0, bcd[4*(int'(DIGITS)-d) +: 4]};
            end
        end
        return ch;
    endfunction

    // Control FSM with conversion datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_char_valid <= 1'b0;
            r_char_data  <= 8'h00;
            r_neg        <= 1'b0;
            r_err        <= 1'b0;
            r_mag        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_ptr        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_neg      <= w_neg;
                        r_err      <= w_err_in;
                        r_mag      <= w_neg ? (~in_value + WIDTH'(1)) : in_value;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_bcd <= {w_adj[BW-2:0], r_mag[WIDTH-1]};
                    r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (!r_char_valid) begin
                        r_char_valid <= 1'b1;
                        r_char_data  <= slot_char(w_first_ptr, r_bcd);
                        r_ptr        <= w_first_ptr;
                    end else if (char_ready) begin
                        if (r_ptr == PW'(SLOT_LF)) begin
                            r_char_valid <= 1'b0;
                            r_in_ready   <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_ptr       <= w_next_ptr;
                            r_char_data <= slot_char(w_next_ptr, r_bcd);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign char_valid = r_char_valid;
    assign char_data  = r_char_data;

endmodule
